// File: rtl/twos_pkg.sv
// Purpose: shared types and defaults for the serial two's-complement to
//          sign-magnitude decoder.
// Contents: state_e (FSM state encoding), DEFAULT_WIDTH.
package twos_pkg;

  // Decoder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    INV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_complement_bit.sv
// Purpose: one-bit Mealy cell for LSB-first magnitude extraction. Bits are
//          copied until the first 1 has passed, then inverted when negative.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load_i         start of a new word; clears the seen-first-one flag
//   shift_i        a serial bit is consumed this cycle
//   sign_i         operand sign; inversion only applies when set
//   in_bit_i       current operand bit (LSB first)
//   out_bit_c_o    combinational magnitude bit for this cycle
//   first_one_c_o  combinational: this bit is the first 1 of the word
module serial_complement_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic shift_i,
  input  logic sign_i,
  input  logic in_bit_i,
  output logic out_bit_c_o,
  output logic first_one_c_o
);

  logic seen_q;
  logic seen_d;

  // Flag is set after the bit that carries the first 1 has been consumed
  always_comb begin
    seen_d = seen_q;
    if (load_i) begin
      seen_d = 1'b0;
    end else if (shift_i && in_bit_i) begin
      seen_d = 1'b1;
    end
  end

  assign out_bit_c_o   = (sign_i && seen_q) ? ~in_bit_i : in_bit_i;
  assign first_one_c_o = in_bit_i & ~seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/twos_to_sign_mag_serial.sv
// Purpose: bit-serial two's-complement to sign-magnitude decoder. One word is
//          accepted per transaction, the magnitude is derived one bit per
//          clock, and the result is offered on a second valid/ready handshake.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   in_valid      operand valid
//   in_ready      decoder idle and able to accept
//   in_data       two's-complement operand
//   out_valid     result valid
//   out_ready     consumer accepts result
//   out_sign      operand sign
//   out_mag       unsigned magnitude
//   out_min_neg   operand was the most negative value
module twos_to_sign_mag_serial
  import twos_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_min_neg
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sign_q, out_sign_d;
  logic [WIDTH-1:0]   out_mag_q, out_mag_d;
  logic               out_min_neg_q, out_min_neg_d;

  logic               accept;
  logic               serial_en;
  logic               bit_out;
  logic               first_one;
  logic [WIDTH-1:0]   acc_next;

  assign accept    = (state_q == IDLE) && in_valid && in_ready_q;
  assign serial_en = (state_q == COPY) || (state_q == INV);

  serial_complement_bit u_cell (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (accept),
    .shift_i       (serial_en),
    .sign_i        (sign_q),
    .in_bit_i      (shift_q[0]),
    .out_bit_c_o   (bit_out),
    .first_one_c_o (first_one)
  );

  // Magnitude bits enter at the MSB end; after WIDTH steps bit k sits at out_mag[k]
  assign acc_next = {bit_out, acc_q[WIDTH-1:1]};

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    sign_d        = sign_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_sign_d    = out_sign_q;
    out_mag_d     = out_mag_q;
    out_min_neg_d = out_min_neg_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d    = in_data;
          sign_d     = in_data[WIDTH-1];
          cnt_d      = '0;
          acc_d      = '0;
          in_ready_d = 1'b0;
          state_d    = COPY;
        end
      end

      COPY, INV: begin
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
        acc_d   = acc_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Publish only the fully built magnitude
          state_d       = DONE;
          out_valid_d   = 1'b1;
          out_sign_d    = sign_q;
          out_mag_d     = acc_next;
          out_min_neg_d = (state_q == COPY) && sign_q && first_one;
        end else if ((state_q == COPY) && sign_q && shift_q[0]) begin
          state_d = INV;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_sign_q    <= 1'b0;
      out_mag_q     <= '0;
      out_min_neg_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sign_q        <= sign_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_sign_q    <= out_sign_d;
      out_mag_q     <= out_mag_d;
      out_min_neg_q <= out_min_neg_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sign    = out_sign_q;
  assign out_mag     = out_mag_q;
  assign out_min_neg = out_min_neg_q;

endmodule

// File: tb/tb_twos_to_sign_mag_serial.sv
// Purpose: self-checking bench for twos_to_sign_mag_serial (WIDTH = 4).
module tb_twos_to_sign_mag_serial;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_min_neg;

  typedef struct packed {
    logic         sign;
    logic [W-1:0] mag;
    logic         mn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   n_res    = 0;
  logic sweep_done;

  twos_to_sign_mag_serial #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_mag     (out_mag),
    .out_min_neg (out_min_neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: sign is the MSB, magnitude is |signed value| as unsigned
  function automatic exp_t model(input logic [W-1:0] d);
    exp_t         e;
    logic [W-1:0] neg;
    logic [W-1:0] min_val;
    neg     = ~d + W'(1);
    min_val = '0;
    min_val[W-1] = 1'b1;
    e.sign = d[W-1];
    e.mag  = d[W-1] ? neg : d;
    e.mn   = (d == min_val);
    return e;
  endfunction

  // Scoreboard: push on input handshake, pop/compare on output handshake
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_res++;
        if (sb.size() == 0) begin
          chk("result_expected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("out_sign", 32'(out_sign), 32'(e.sign));
          chk("out_mag", 32'(out_mag), 32'(e.mag));
          chk("out_min_neg", 32'(out_min_neg), 32'(e.mn));
        end
      end
    end
  end

  // Present a word (inputs already at posedge+1) and wait for its acceptance edge
  task automatic send(input logic [W-1:0] d);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 15);
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("valid_timeout", 32'(ok), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [W-1:0] dir_vals [4];
    int acc0, res0;
    dir_vals[0] = 4'b1011;
    dir_vals[1] = 4'b1110;
    dir_vals[2] = 4'b1000;
    dir_vals[3] = 4'b0000;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    sweep_done = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sign", 32'(out_sign), 32'd0);
    chk("rst_out_mag", 32'(out_mag), 32'd0);
    chk("rst_out_min_neg", 32'(out_min_neg), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: valid appears exactly WIDTH edges after acceptance
    send(4'b0101);
    for (int i = 1; i < int'(W); i++) begin
      @(posedge clk);
      #1;
      chk("lat_early_valid", 32'(out_valid), 32'd0);
      chk("busy_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("valid_dropped", 32'(out_valid), 32'd0);
    drain();

    // Directed operands: negative, zero-before-first-one, most negative, zero
    foreach (dir_vals[k]) begin
      send(dir_vals[k]);
      drain();
    end

    // Backpressure with a busy-time input that must not be captured
    out_ready = 1'b0;
    send(4'b1111);
    wait_valid();
    in_valid = 1'b1;
    in_data  = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sign", 32'(out_sign), 32'd1);
      chk("bp_mag", 32'(out_mag), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sb_depth", 32'(sb.size()), 32'd1);
    end
    out_ready = 1'b1;
    send(4'b0011);
    drain();

    // Asynchronous reset mid-operation
    send(4'b1010);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_mag", 32'(out_mag), 32'd0);
    chk("mid_rst_out_sign", 32'(out_sign), 32'd0);
    chk("mid_rst_out_min_neg", 32'(out_min_neg), 32'd0);
    sb.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'b0110);
    drain();

    // Exhaustive sweep with random consumer stalls
    acc0 = n_acc;
    res0 = n_res;
    fork
      begin
        for (int d = 0; d < 16; d++) send(W'(d));
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("sweep_accepts", 32'(n_acc - acc0), 32'd16);
    chk("sweep_results", 32'(n_res - res0), 32'(n_acc - acc0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
